// File: rtl/serial_slave_port.sv
// Serial bus responder: shifts in address/write data LSB first, accesses a local
// register-array memory and shifts read data back out on tx_data.
module serial_slave_port #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic rx_address,
    input  logic rx_data,
    input  logic write_en,
    input  logic read_en,
    output logic tx_data,
    output logic slave_ready
);

    localparam int unsigned MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CW   = $clog2(MAXW);
    localparam int unsigned MW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RLOAD,
        RDATA
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  rd_q, rd_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH);
    assign rdata    = in_range ? mem[addr_q[MW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            shreg_q <= '0;
            rd_q    <= 1'b0;
            tx_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shreg_q <= shreg_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[MW-1:0]] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shreg_d = shreg_q;
        rd_d    = rd_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid && (write_en ^ read_en)) begin
                    addr_d  = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    rd_d    = read_en;
                    cnt_d   = CW'(1);
                    ready_d = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (valid) begin
                    // After ADDR_WIDTH right shifts the first bit lands in addr_q[0]
                    addr_d = {rx_address, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = rd_q ? RLOAD : WDATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WDATA: begin
                if (valid) begin
                    wdata_d = {rx_data, wdata_q[DATA_WIDTH-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WRITE: begin
                mem_we  = in_range;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            RLOAD: begin
                // Bit 0 goes straight to tx so it is visible on the first RDATA cycle
                if (valid) begin
                    tx_d    = rdata[0];
                    shreg_d = rdata >> 1;
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (valid) begin
                    if (cnt_q == DATA_LAST) begin
                        tx_d    = 1'b0;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!valid && (state_q == ADDR || state_q == WDATA ||
                       state_q == RLOAD || state_q == RDATA)) begin
            state_d = IDLE;
            ready_d = 1'b1;
            tx_d    = 1'b0;
            cnt_d   = '0;
        end
    end

    assign tx_data     = tx_q;
    assign slave_ready = ready_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Bench for serial_slave_port: full-depth and 16-word instances share stimulus.
module tb_serial_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid = 1'b0;
    logic rx_address = 1'b0;
    logic rx_data = 1'b0;
    logic write_en = 1'b0;
    logic read_en = 1'b0;
    logic tx_a, rdy_a, tx_b, rdy_b;
    logic mon_sel = 1'b0;
    logic tx_mon, rdy_mon;

    int total = 0;
    int bad = 0;
    logic exp_q[$];

    typedef struct {
        bit          rd;
        bit          sel;
        logic [11:0] addr;
        logic [7:0]  data;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    assign tx_mon  = mon_sel ? tx_b : tx_a;
    assign rdy_mon = mon_sel ? rdy_b : rdy_a;

    serial_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4096)) dut_a (
        .clk(clk), .rst(rst), .valid(valid), .rx_address(rx_address), .rx_data(rx_data),
        .write_en(write_en), .read_en(read_en), .tx_data(tx_a), .slave_ready(rdy_a)
    );

    serial_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .valid(valid), .rx_address(rx_address), .rx_data(rx_data),
        .write_en(write_en), .read_en(read_en), .tx_data(tx_b), .slave_ready(rdy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called on a negedge with the slave idle; returns on the negedge where ready rises,
    // so a following call starts back-to-back.
    task automatic xfer(input bit is_rd, input logic [11:0] addr, input logic [7:0] data);
        int lo = 0;
        logic e;
        valid = 1'b1;
        write_en = !is_rd;
        read_en = is_rd;
        rx_address = addr[0];
        if (is_rd) for (int i = 0; i < DW; i++) exp_q.push_back(data[i]);
        for (int c = 1; c <= AW + DW; c++) begin
            @(negedge clk);
            if (c == 1) begin
                write_en = is_rd;
                read_en = !is_rd;
            end
            if (!rdy_mon) lo++;
            if (c < AW) rx_address = addr[c];
            if (!is_rd && c >= AW && c < AW + DW) rx_data = data[c - AW];
            if (is_rd && c == AW) check("rload_tx", 32'(tx_mon), 32'd0);
            if (is_rd && c > AW) begin
                e = exp_q.pop_front();
                check("rd_bit", 32'(tx_mon), 32'(e));
            end
        end
        @(negedge clk);
        check("done_ready", 32'(rdy_mon), 32'd1);
        check("done_tx", 32'(tx_mon), 32'd0);
        check("ready_low_cycles", 32'(lo), 32'(AW + DW));
        valid = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
    endtask

    initial begin
        logic [11:0] a;
        logic [7:0]  d;

        vecs[0]  = '{rd: 1'b0, sel: 1'b0, addr: 12'h012, data: 8'hA5};
        vecs[1]  = '{rd: 1'b1, sel: 1'b0, addr: 12'h012, data: 8'hA5};
        vecs[2]  = '{rd: 1'b0, sel: 1'b0, addr: 12'h000, data: 8'h3C};
        vecs[3]  = '{rd: 1'b0, sel: 1'b0, addr: 12'hFFF, data: 8'hFF};
        vecs[4]  = '{rd: 1'b1, sel: 1'b0, addr: 12'h000, data: 8'h3C};
        vecs[5]  = '{rd: 1'b1, sel: 1'b0, addr: 12'hFFF, data: 8'hFF};
        vecs[6]  = '{rd: 1'b0, sel: 1'b1, addr: 12'h005, data: 8'h5A};
        vecs[7]  = '{rd: 1'b1, sel: 1'b1, addr: 12'h005, data: 8'h5A};
        vecs[8]  = '{rd: 1'b0, sel: 1'b1, addr: 12'h020, data: 8'h77};
        vecs[9]  = '{rd: 1'b1, sel: 1'b1, addr: 12'h020, data: 8'h00};
        vecs[10] = '{rd: 1'b1, sel: 1'b1, addr: 12'h000, data: 8'h3C};

        // Reset and idle behaviour
        tick(2);
        check("rst_ready_a", 32'(rdy_a), 32'd1);
        check("rst_tx_a", 32'(tx_a), 32'd0);
        check("rst_ready_b", 32'(rdy_b), 32'd1);
        check("rst_tx_b", 32'(tx_b), 32'd0);
        rst = 1'b1;
        tick(1);
        valid = 1'b1;
        write_en = 1'b1;
        read_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("both_en_idle", 32'(rdy_a), 32'd1);
        end
        write_en = 1'b0;
        read_en = 1'b0;
        tick(2);
        check("no_en_idle", 32'(rdy_a), 32'd1);
        valid = 1'b0;
        tick(1);

        // Table: writes/reads, back-to-back pairs, out-of-range on the 16-word instance
        for (int v = 0; v < 11; v++) begin
            mon_sel = vecs[v].sel;
            xfer(vecs[v].rd, vecs[v].addr, vecs[v].data);
            if (v == 1 || v == 5 || v == 9) tick(2);
        end
        mon_sel = 1'b0;
        tick(2);

        // Abort after 5 address bits of a write to 0x012
        a = 12'h012;
        valid = 1'b1;
        write_en = 1'b1;
        rx_address = a[0];
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            rx_address = a[c];
        end
        @(negedge clk);
        check("abort_addr_busy", 32'(rdy_a), 32'd0);
        valid = 1'b0;
        write_en = 1'b0;
        @(negedge clk);
        check("abort_addr_ready", 32'(rdy_a), 32'd1);
        tick(1);

        // Abort during write data: memory must be untouched
        d = 8'h00;
        valid = 1'b1;
        write_en = 1'b1;
        rx_address = a[0];
        for (int c = 1; c <= AW + 2; c++) begin
            @(negedge clk);
            if (c < AW) rx_address = a[c];
            else rx_data = d[c - AW];
        end
        @(negedge clk);
        check("abort_wdata_busy", 32'(rdy_a), 32'd0);
        valid = 1'b0;
        write_en = 1'b0;
        @(negedge clk);
        check("abort_wdata_ready", 32'(rdy_a), 32'd1);
        tick(DW + 3);
        xfer(1'b1, 12'h012, 8'hA5);
        tick(1);

        // Abort mid read data while bit 4 (0) is showing; bit 5 would be 1
        valid = 1'b1;
        read_en = 1'b1;
        rx_address = a[0];
        for (int c = 1; c <= AW + 5; c++) begin
            @(negedge clk);
            if (c < AW) rx_address = a[c];
        end
        check("rdata_bit4", 32'(tx_a), 32'd0);
        valid = 1'b0;
        read_en = 1'b0;
        @(negedge clk);
        check("abort_rdata_tx", 32'(tx_a), 32'd0);
        check("abort_rdata_ready", 32'(rdy_a), 32'd1);
        tick(2);
        check("post_abort_tx", 32'(tx_a), 32'd0);

        // Asynchronous reset during write data
        d = 8'h11;
        valid = 1'b1;
        write_en = 1'b1;
        rx_address = a[0];
        for (int c = 1; c <= AW + 4; c++) begin
            @(negedge clk);
            if (c < AW) rx_address = a[c];
            else rx_data = d[c - AW];
        end
        check("pre_reset_busy", 32'(rdy_a), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ready", 32'(rdy_a), 32'd1);
        check("async_rst_tx", 32'(tx_a), 32'd0);
        valid = 1'b0;
        write_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        xfer(1'b1, 12'h012, 8'hA5);
        tick(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
